// File: rtl/addr_arbiter_if.sv
// Bus bundle between the requesters, the shared adder and the result consumer.
// The arbiter takes the slave view and the requester/consumer side takes the master view.
interface addr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic               en;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic [W-1:0]       add_a_o;
  logic [W-1:0]       add_b_o;
  logic [W:0]         add_c_i;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [W:0]         rsp_sum;
  logic               rsp_ready;
  logic               busy;

  modport slave (
    input  en, req_valid, req_a, req_b, add_c_i, rsp_ready,
    output req_ready, add_a_o, add_b_o, rsp_valid, rsp_id, rsp_sum, busy
  );

  modport master (
    output en, req_valid, req_a, req_b, add_c_i, rsp_ready,
    input  req_ready, add_a_o, add_b_o, rsp_valid, rsp_id, rsp_sum, busy
  );
endinterface

// File: rtl/addr_arbiter.sv
// Round-robin scheduler sharing one registered adder among N_REQ requesters;
// results come back tagged with the index of the requester that issued them.
module addr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 4,
  parameter int ADD_LAT = 1,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic           clk,
  input  logic           rst,
  addr_arbiter_if.slave  bus
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [ID_W-1:0] id_q;
  logic [W:0]      sum_q;
  logic            rsp_valid_q;
  logic            busy_q;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W:0]   idx;
  logic            grant;
  logic [ID_W-1:0] next_ptr;

  // Search upward from ptr with wrap; idx is one bit wider so ptr+k cannot overflow.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) begin
        idx = idx - (ID_W+1)'(N_REQ);
      end
      if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  assign grant    = bus.en && (state == IDLE) && found;
  assign next_ptr = (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);

  always_comb begin
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      id_q        <= '0;
      sum_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_a   <= bus.req_a[int'(winner)*W +: W];
            op_b   <= bus.req_b[int'(winner)*W +: W];
            id_q   <= winner;
            ptr    <= next_ptr;
            busy_q <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(ADD_LAT);
          state <= WAIT;
        end
        WAIT: begin
          // The adder output is trusted only once the latency countdown has expired.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            sum_q       <= bus.add_c_i;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.add_a_o   = op_a;
  assign bus.add_b_o   = op_b;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_addr_arbiter.sv
// Directed bench for addr_arbiter: expected grants and tagged sums are queued as
// stimulus is issued, and negedge monitors pop and compare them as the DUT presents them.
module tb_addr_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int         exp_grant[$];
  logic [6:0] exp_rsp[$];

  addr_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  addr_arbiter #(.N_REQ(N_REQ), .W(W), .ADD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered adder with one cycle of latency.
  always @(posedge clk) begin
    bus.add_c_i <= {1'b0, bus.add_a_o} + {1'b0, bus.add_b_o};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event happened, expected it not to (or timeout)", name);
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid = valid;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  task automatic waitGrant(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if ((bus.req_ready & bus.req_valid) != '0) seen = 1'b1;
    end
    if (!seen) reportFail(name);
  endtask

  task automatic waitHandshake(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) seen = 1'b1;
    end
    if (!seen) reportFail(name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_ready != '0) begin
        checkOutput("grant_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        if (exp_grant.size() == 0) begin
          reportFail("unexpected_grant");
        end else begin
          checkOutput("grant_order", 32'(bus.req_ready), 32'(4'b0001 << exp_grant.pop_front()));
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          reportFail("unexpected_response");
        end else begin
          checkOutput("rsp_id_sum", 32'({bus.rsp_id, bus.rsp_sum}), 32'(exp_rsp.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.rsp_ready = 1'b0;
    applyStimulus(4'b0000, 16'h0000, 16'h0000);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset_add_a", 32'(bus.add_a_o), 32'd0);
    checkOutput("reset_add_b", 32'(bus.add_b_o), 32'd0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("reset_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request: requester 0, 3+5, response four cycles after accept
    @(posedge clk); #1;
    bus.en = 1'b1;
    bus.rsp_ready = 1'b1;
    applyStimulus(4'b0001, 16'h0003, 16'h0005);
    exp_grant.push_back(0);
    exp_rsp.push_back({2'd0, 5'h08});
    @(negedge clk);
    checkOutput("single_req_ready", 32'(bus.req_ready), 32'b0001);
    @(posedge clk); #1 applyStimulus(4'b0000, 16'h0000, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("single_busy", 32'(bus.busy), 32'd1);
      checkOutput("single_rsp_latency", 32'(bus.rsp_valid), 32'(k == 4));
      if (k == 1) begin
        checkOutput("single_add_a", 32'(bus.add_a_o), 32'd3);
        checkOutput("single_add_b", 32'(bus.add_b_o), 32'd5);
      end
    end
    @(negedge clk);
    checkOutput("single_idle_busy", 32'(bus.busy), 32'd0);

    // Carry: requester 2, 0xF+0xF
    @(posedge clk); #1;
    applyStimulus(4'b0100, 16'h0F00, 16'h0F00);
    exp_grant.push_back(2);
    exp_rsp.push_back({2'd2, 5'h1E});
    waitGrant("carry_grant_timeout");
    @(posedge clk); #1 applyStimulus(4'b0000, 16'h0000, 16'h0000);
    waitHandshake("carry_rsp_timeout");

    // Async reset during WAIT discards the in-flight result (ptr is 3 here, winner is 1)
    @(posedge clk); #1;
    applyStimulus(4'b0010, 16'h0010, 16'h0020);
    exp_grant.push_back(1);
    waitGrant("reset_grant_timeout");
    @(posedge clk); #1 applyStimulus(4'b0000, 16'h0000, 16'h0000);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checkOutput("async_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("async_add_a", 32'(bus.add_a_o), 32'd0);
    checkOutput("async_add_b", 32'(bus.add_b_o), 32'd0);
    checkOutput("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("async_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("async_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    checkOutput("async_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("post_reset_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Round robin from ptr=0 with all four requesters held valid
    @(posedge clk); #1;
    applyStimulus(4'b1111, 16'h4321, 16'hBA98);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    exp_rsp.push_back({2'd0, 5'h09}); exp_rsp.push_back({2'd1, 5'h0B});
    exp_rsp.push_back({2'd2, 5'h0D}); exp_rsp.push_back({2'd3, 5'h0F});
    exp_rsp.push_back({2'd0, 5'h09});
    for (int c = 0; c < 100 && exp_grant.size() != 0; c++) @(negedge clk);
    if (exp_grant.size() != 0) reportFail("rr_grant_timeout");
    @(posedge clk); #1 applyStimulus(4'b0000, 16'h0000, 16'h0000);
    for (int c = 0; c < 100 && exp_rsp.size() != 0; c++) @(negedge clk);
    if (exp_rsp.size() != 0) reportFail("rr_rsp_timeout");
    @(posedge clk); #1;

    // Backpressure: requester 3 wins from ptr=1 while requester 0 stays pending
    bus.rsp_ready = 1'b0;
    applyStimulus(4'b1001, 16'hA006, 16'h7006);
    exp_grant.push_back(3); exp_grant.push_back(0);
    exp_rsp.push_back({2'd3, 5'h11}); exp_rsp.push_back({2'd0, 5'h0C});
    waitGrant("bp_grant_timeout");
    @(posedge clk); #1 applyStimulus(4'b0001, 16'hA006, 16'h7006);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (bus.rsp_valid) seen = 1'b1;
      end
      if (!seen) reportFail("bp_rsp_timeout");
    end
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_rsp_sum", 32'(bus.rsp_sum), 32'h11);
      checkOutput("bp_rsp_id", 32'(bus.rsp_id), 32'd3);
      checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_single_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1 applyStimulus(4'b0000, 16'h0000, 16'h0000);
    waitHandshake("bp_second_rsp_timeout");

    // en gating: drop en during WAIT with requester 1 pending
    @(posedge clk); #1;
    applyStimulus(4'b0100, 16'h0500, 16'h0500);
    exp_grant.push_back(2); exp_grant.push_back(1);
    exp_rsp.push_back({2'd2, 5'h0A}); exp_rsp.push_back({2'd1, 5'h0C});
    waitGrant("en_grant_timeout");
    @(posedge clk); #1 applyStimulus(4'b0010, 16'h0090, 16'h0030);
    @(posedge clk); #1 bus.en = 1'b0;
    waitHandshake("en_rsp_timeout");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("en_low_no_grant", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1 bus.en = 1'b1;
    @(negedge clk);
    checkOutput("en_high_grant", 32'(bus.req_ready), 32'b0010);
    @(posedge clk); #1 applyStimulus(4'b0000, 16'h0000, 16'h0000);
    waitHandshake("en_second_rsp_timeout");
    @(posedge clk); #1;

    checkOutput("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
    checkOutput("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
